// File: rtl/rv_irq_ctrl.sv
// rv_irq_ctrl: platform-level interrupt controller with a Wishbone B4 classic slave port.
// It collects NUM_SRC external sources and supports edge or level mode, priority and
// threshold per source. Claim/complete handshaking is done through register 0x10.
module rv_irq_ctrl #(
    parameter int unsigned NUM_SRC     = 8,
    parameter int unsigned PRIO_W      = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               CLK_I,
    input  logic               RST_I,
    input  logic               CYC_I,
    input  logic               STB_I,
    input  logic               WE_I,
    input  logic [7:0]         ADR_I,
    input  logic [31:0]        DAT_I,
    input  logic [3:0]         SEL_I,
    output logic               ACK_O,
    output logic [31:0]        DAT_O,
    input  logic [NUM_SRC-1:0] src_i,
    output logic               irq_o
);

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] sync_prev_q;
    logic [NUM_SRC-1:0] sync_lvl;
    logic [NUM_SRC-1:0] rise;

    logic [NUM_SRC-1:0] enable_q, mode_q, pend_q, in_srv_q;
    logic [PRIO_W-1:0]  thr_q;
    logic [PRIO_W-1:0]  prio_q [NUM_SRC];
    logic [4:0]         best_id_q;
    logic               ack_q, irq_q;

    logic [NUM_SRC-1:0] enable_n, mode_n, pend_n, in_srv_n;
    logic [PRIO_W-1:0]  thr_n;
    logic [NUM_SRC-1:0] pending, elig, claim_mask, cmpl_mask, mode_chg;
    logic [4:0]         best_id_n;
    logic [PRIO_W-1:0]  best_prio;

    logic               acc, wr, rd;
    logic [5:0]         word, prio_idx;
    logic               hit_pend, hit_en, hit_mode, hit_thr, hit_claim, hit_prio;
    logic [31:0]        wmask, rdata;

    logic unused_bits;
    assign unused_bits = ^{ADR_I[1:0], DAT_I};

    assign sync_lvl = sync_q[SYNC_STAGES-1];
    assign rise     = sync_lvl & ~sync_prev_q;
    assign pending  = (mode_q & pend_q) | (~mode_q & sync_lvl);

    assign ACK_O = ack_q;
    assign irq_o = irq_q;

    // Bus access decode; side effects only take place during the ACK cycle.
    always_comb begin
        acc       = ack_q & CYC_I & STB_I;
        wr        = acc & WE_I;
        rd        = acc & ~WE_I;
        word      = ADR_I[7:2];
        prio_idx  = word - 6'd16;
        hit_pend  = (word == 6'h00);
        hit_en    = (word == 6'h01);
        hit_mode  = (word == 6'h02);
        hit_thr   = (word == 6'h03);
        hit_claim = (word == 6'h04);
        hit_prio  = (word >= 6'd16) && (prio_idx < 6'(NUM_SRC));
        wmask     = {{8{SEL_I[3]}}, {8{SEL_I[2]}}, {8{SEL_I[1]}}, {8{SEL_I[0]}}};
    end

    // Next-state logic for the control registers, the pending bits and in-service.
    always_comb begin
        enable_n   = enable_q;
        mode_n     = mode_q;
        thr_n      = thr_q;
        claim_mask = '0;
        cmpl_mask  = '0;
        mode_chg   = '0;
        if (wr && hit_en)
            enable_n = (enable_q & ~wmask[NUM_SRC-1:0]) | (DAT_I[NUM_SRC-1:0] & wmask[NUM_SRC-1:0]);
        if (wr && hit_mode) begin
            mode_n   = (mode_q & ~wmask[NUM_SRC-1:0]) | (DAT_I[NUM_SRC-1:0] & wmask[NUM_SRC-1:0]);
            mode_chg = mode_q ^ mode_n;
        end
        if (wr && hit_thr)
            thr_n = (thr_q & ~wmask[PRIO_W-1:0]) | (DAT_I[PRIO_W-1:0] & wmask[PRIO_W-1:0]);
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            claim_mask[i] = rd && hit_claim && (best_id_q == 5'(i + 1));
            cmpl_mask[i]  = wr && hit_claim && (DAT_I[4:0] == 5'(i + 1));
        end
        in_srv_n = (in_srv_q | claim_mask) & ~cmpl_mask;
        // A rising edge in the same cycle as a claim or mode change still wins.
        pend_n   = (pend_q & ~claim_mask & ~mode_chg) | (rise & mode_q);
    end

    // Arbitration. Using next-cycle in-service lets irq_o drop or re-assert the cycle
    // right after a claim or complete ACK, instead of one cycle later.
    always_comb begin
        best_prio = '0;
        best_id_n = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            elig[i] = pending[i] & enable_q[i] & ~in_srv_n[i] & (prio_q[i] > thr_q);
            if (elig[i] && (prio_q[i] > best_prio)) begin
                best_prio = prio_q[i];
                best_id_n = 5'(i + 1);
            end
        end
    end

    // Register read multiplexer; DAT_O carries data only while ACK_O is high.
    always_comb begin
        rdata = '0;
        if (hit_pend)  rdata = 32'(pending);
        if (hit_en)    rdata = 32'(enable_q);
        if (hit_mode)  rdata = 32'(mode_q);
        if (hit_thr)   rdata = 32'(thr_q);
        if (hit_claim) rdata = 32'(best_id_q);
        for (int unsigned i = 0; i < NUM_SRC; i++)
            if (hit_prio && (prio_idx == 6'(i))) rdata = 32'(prio_q[i]);
        DAT_O = ack_q ? rdata : '0;
    end

    // Source synchroniser chain, plus the previous synchronised value for edge detection.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            sync_prev_q <= '0;
        end else begin
            sync_q[0] <= src_i;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            sync_prev_q <= sync_lvl;
        end
    end

    // Control, pending, in-service, arbitration result and bus handshake registers.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            enable_q  <= '0;
            mode_q    <= '0;
            pend_q    <= '0;
            in_srv_q  <= '0;
            thr_q     <= '0;
            for (int unsigned i = 0; i < NUM_SRC; i++) prio_q[i] <= '0;
            best_id_q <= '0;
            irq_q     <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            enable_q  <= enable_n;
            mode_q    <= mode_n;
            pend_q    <= pend_n;
            in_srv_q  <= in_srv_n;
            thr_q     <= thr_n;
            for (int unsigned i = 0; i < NUM_SRC; i++)
                if (wr && hit_prio && (prio_idx == 6'(i)))
                    prio_q[i] <= (prio_q[i] & ~wmask[PRIO_W-1:0]) | (DAT_I[PRIO_W-1:0] & wmask[PRIO_W-1:0]);
            best_id_q <= best_id_n;
            irq_q     <= (best_id_n != 5'd0);
            ack_q     <= CYC_I & STB_I & ~ack_q;
        end
    end

endmodule

// File: tb/tb_rv_irq_ctrl.sv
// Directed self-checking bench for rv_irq_ctrl (NUM_SRC=8, PRIO_W=3, SYNC_STAGES=2).
module tb_rv_irq_ctrl;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b0;
    logic        CYC_I = 1'b0, STB_I = 1'b0, WE_I = 1'b0;
    logic [7:0]  ADR_I = '0;
    logic [31:0] DAT_I = '0;
    logic [3:0]  SEL_I = '0;
    logic        ACK_O;
    logic [31:0] DAT_O;
    logic [7:0]  src_i = '0;
    logic        irq_o;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic        last_ack1, last_ack2;

    rv_irq_ctrl #(.NUM_SRC(8), .PRIO_W(3), .SYNC_STAGES(2)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
        .ADR_I(ADR_I), .DAT_I(DAT_I), .SEL_I(SEL_I), .ACK_O(ACK_O), .DAT_O(DAT_O),
        .src_i(src_i), .irq_o(irq_o)
    );

    always #5 CLK_I = ~CLK_I;

    // One classic cycle: strobe, sample on the ACK cycle, hold through the ACK edge.
    task automatic wb_xfer(input logic we, input logic [7:0] adr, input logic [31:0] wd,
                           input logic [3:0] sel, output logic [31:0] rdat);
        @(posedge CLK_I); #1;
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = wd; SEL_I = sel;
        @(posedge CLK_I); #1;
        last_ack1 = ACK_O;
        rdat      = DAT_O;
        @(posedge CLK_I); #1;
        last_ack2 = ACK_O;
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    endtask

    task automatic wb_wr(input logic [7:0] adr, input logic [31:0] wd);
        logic [31:0] dummy;
        wb_xfer(1'b1, adr, wd, 4'hF, dummy);
    endtask

    task automatic wb_rd(input logic [7:0] adr, output logic [31:0] rdat);
        wb_xfer(1'b0, adr, 32'h0, 4'hF, rdat);
    endtask

    task automatic do_reset;
        src_i = '0;
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        #2 RST_I = 1'b0;
        repeat (2) @(posedge CLK_I);
        #3 RST_I = 1'b1;
    endtask

    task automatic test_reset;
        logic [7:0]  addrs [7];
        logic [31:0] r;
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h40, 8'h5C};
        RST_I = 1'b0;
        #7;
        tests++;
        if ({irq_o, ACK_O, DAT_O} !== 34'h0) begin
            fails++;
            $display("FAIL reset_outputs: irq=%b ack=%b dat=%h required 0", irq_o, ACK_O, DAT_O);
        end
        do_reset();
        foreach (addrs[k]) begin
            wb_rd(addrs[k], r);
            tests++;
            if (r !== 32'h0 || last_ack1 !== 1'b1 || last_ack2 !== 1'b0) begin
                fails++;
                $display("FAIL reset_read_%h: data=%h ack=%b%b required data=0 ack=10", addrs[k], r, last_ack1, last_ack2);
            end
        end
        tests++;
        if (irq_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_irq: got %b required 0", irq_o);
        end
        wb_wr(8'h08, 32'hFFFF_FFFF);
        wb_rd(8'h08, r);
        tests++;
        if (r !== 32'h0000_00FF) begin
            fails++;
            $display("FAIL mode_width: got %h required 000000ff", r);
        end
        wb_xfer(1'b1, 8'h04, 32'hFF, 4'h0, r);
        wb_rd(8'h04, r);
        tests++;
        if (r !== 32'h0) begin
            fails++;
            $display("FAIL sel_lanes: got %h required 0", r);
        end
        wb_wr(8'h20, 32'hFFFF_FFFF);
        wb_rd(8'h20, r);
        tests++;
        if (r !== 32'h0) begin
            fails++;
            $display("FAIL unmapped: got %h required 0", r);
        end
    endtask

    task automatic pulse_src3;
        @(posedge CLK_I); #1 src_i[2] = 1'b1;
        @(posedge CLK_I); #1 src_i[2] = 1'b0;
    endtask

    task automatic test_edge;
        logic [31:0] r;
        do_reset();
        wb_wr(8'h08, 32'h04);
        wb_wr(8'h04, 32'h04);
        wb_wr(8'h48, 32'h2);
        wb_wr(8'h0C, 32'h0);
        pulse_src3();
        @(posedge CLK_I); @(posedge CLK_I); #1;
        tests++;
        if (irq_o !== 1'b0) begin
            fails++;
            $display("FAIL edge_latency_early: irq=%b required 0", irq_o);
        end
        @(posedge CLK_I); #1;
        tests++;
        if (irq_o !== 1'b1) begin
            fails++;
            $display("FAIL edge_latency: irq=%b required 1", irq_o);
        end
        wb_rd(8'h00, r);
        tests++;
        if (r !== 32'h04) begin
            fails++;
            $display("FAIL edge_pending: got %h required 04", r);
        end
        wb_rd(8'h10, r);
        tests++;
        if (r !== 32'd3 || irq_o !== 1'b0) begin
            fails++;
            $display("FAIL edge_claim: id=%0d irq=%b required id=3 irq=0", r, irq_o);
        end
        wb_rd(8'h00, r);
        tests++;
        if (r !== 32'h0) begin
            fails++;
            $display("FAIL edge_pending_cleared: got %h required 0", r);
        end
        wb_wr(8'h10, 32'd3);
        pulse_src3();
        repeat (5) @(posedge CLK_I);
        wb_rd(8'h10, r);
        tests++;
        if (r !== 32'd3) begin
            fails++;
            $display("FAIL edge_reclaim_after_complete: id=%0d required 3", r);
        end
    endtask

    task automatic test_tie_and_complete;
        logic [31:0] r;
        do_reset();
        wb_wr(8'h04, 32'h12);
        wb_wr(8'h44, 32'h4);
        wb_wr(8'h50, 32'h4);
        src_i = 8'h12;
        repeat (4) @(posedge CLK_I);
        wb_rd(8'h10, r);
        tests++;
        if (r !== 32'd2) begin
            fails++;
            $display("FAIL tie_claim1: id=%0d required 2", r);
        end
        wb_rd(8'h10, r);
        tests++;
        if (r !== 32'd5) begin
            fails++;
            $display("FAIL tie_claim2: id=%0d required 5", r);
        end
        wb_rd(8'h10, r);
        tests++;
        if (r !== 32'd0 || irq_o !== 1'b0) begin
            fails++;
            $display("FAIL tie_claim3: id=%0d irq=%b required id=0 irq=0", r, irq_o);
        end
        wb_rd(8'h00, r);
        tests++;
        if (r !== 32'h12) begin
            fails++;
            $display("FAIL level_pending: got %h required 12", r);
        end
        wb_wr(8'h10, 32'd9);
        wb_wr(8'h10, 32'd3);
        tests++;
        if (irq_o !== 1'b0) begin
            fails++;
            $display("FAIL bad_complete: irq=%b required 0", irq_o);
        end
        wb_wr(8'h10, 32'd2);
        tests++;
        if (irq_o !== 1'b1) begin
            fails++;
            $display("FAIL level_reassert: irq=%b required 1", irq_o);
        end
        wb_rd(8'h10, r);
        tests++;
        if (r !== 32'd2) begin
            fails++;
            $display("FAIL level_reclaim: id=%0d required 2", r);
        end
        src_i = '0;
    endtask

    task automatic test_threshold;
        logic [31:0] r;
        do_reset();
        wb_wr(8'h04, 32'h41);
        wb_wr(8'h40, 32'h1);
        wb_wr(8'h58, 32'h6);
        wb_wr(8'h0C, 32'h5);
        src_i = 8'h41;
        repeat (4) @(posedge CLK_I);
        #1;
        tests++;
        if (irq_o !== 1'b1) begin
            fails++;
            $display("FAIL thr_irq: irq=%b required 1", irq_o);
        end
        wb_rd(8'h10, r);
        tests++;
        if (r !== 32'd7 || irq_o !== 1'b0) begin
            fails++;
            $display("FAIL thr_claim: id=%0d irq=%b required id=7 irq=0", r, irq_o);
        end
        wb_wr(8'h10, 32'd7);
        tests++;
        if (irq_o !== 1'b1) begin
            fails++;
            $display("FAIL thr_complete: irq=%b required 1", irq_o);
        end
        wb_wr(8'h0C, 32'h6);
        @(posedge CLK_I); #1;
        tests++;
        if (irq_o !== 1'b0) begin
            fails++;
            $display("FAIL thr_raise: irq=%b required 0", irq_o);
        end
        wb_rd(8'h10, r);
        tests++;
        if (r !== 32'd0) begin
            fails++;
            $display("FAIL thr_claim_none: id=%0d required 0", r);
        end
        src_i = '0;
    endtask

    task automatic test_edge_during_claim;
        logic [31:0] r;
        do_reset();
        wb_wr(8'h08, 32'h04);
        wb_wr(8'h04, 32'h04);
        wb_wr(8'h48, 32'h2);
        pulse_src3();
        repeat (6) @(posedge CLK_I);
        #1 src_i[2] = 1'b1;
        wb_rd(8'h10, r);
        tests++;
        if (r !== 32'd3 || irq_o !== 1'b0) begin
            fails++;
            $display("FAIL collide_claim: id=%0d irq=%b required id=3 irq=0", r, irq_o);
        end
        wb_rd(8'h00, r);
        tests++;
        if (r !== 32'h04) begin
            fails++;
            $display("FAIL collide_pending: got %h required 04", r);
        end
        wb_wr(8'h10, 32'd3);
        tests++;
        if (irq_o !== 1'b1) begin
            fails++;
            $display("FAIL collide_complete: irq=%b required 1", irq_o);
        end
        wb_rd(8'h10, r);
        tests++;
        if (r !== 32'd3) begin
            fails++;
            $display("FAIL collide_reclaim: id=%0d required 3", r);
        end
        src_i = '0;
    endtask

    task automatic test_async_reset;
        logic [31:0] r;
        do_reset();
        wb_wr(8'h04, 32'h01);
        wb_wr(8'h40, 32'h3);
        src_i = 8'h01;
        repeat (4) @(posedge CLK_I);
        @(posedge CLK_I); #1;
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADR_I = 8'h10; SEL_I = 4'hF;
        @(posedge CLK_I); #2;
        tests++;
        if (ACK_O !== 1'b1 || irq_o !== 1'b1 || DAT_O !== 32'd1) begin
            fails++;
            $display("FAIL pre_reset: ack=%b irq=%b dat=%h required 1 1 1", ACK_O, irq_o, DAT_O);
        end
        RST_I = 1'b0;
        #1;
        tests++;
        if (ACK_O !== 1'b0 || irq_o !== 1'b0 || DAT_O !== 32'h0) begin
            fails++;
            $display("FAIL async_reset: ack=%b irq=%b dat=%h required 0 0 0", ACK_O, irq_o, DAT_O);
        end
        CYC_I = 1'b0; STB_I = 1'b0;
        src_i = '0;
        @(posedge CLK_I); #3 RST_I = 1'b1;
        wb_rd(8'h04, r);
        tests++;
        if (r !== 32'h0 || irq_o !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_enable: got %h irq=%b required 0 0", r, irq_o);
        end
        wb_rd(8'h40, r);
        tests++;
        if (r !== 32'h0) begin
            fails++;
            $display("FAIL post_reset_prio: got %h required 0", r);
        end
    endtask

    initial begin
        test_reset();
        test_edge();
        test_tie_and_complete();
        test_threshold();
        test_edge_during_claim();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv_irq_ctrl.md
Name: rv_irq_ctrl

Overview:
- Parametrised platform-level interrupt controller for the rv32im SoC, replacing the direct 8-bit external IRQ bus into the core.
- Collects NUM_SRC external sources and supports per-source edge/level mode, per-source priority and a global threshold.
- Provides claim/complete handshaking through a Wishbone B4 classic slave port.
- Drives one level interrupt into the core's machine external interrupt input.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..31); source IDs are 1..NUM_SRC, and ID 0 means "none".
PRIO_W, 3, priority field width; priority 0 disables a source.
SYNC_STAGES, 2, synchroniser flops on each src_i bit (minimum 2).

Ports:
CLK_I  in  1  system clock
RST_I  in  1  reset; asynchronous, active-low
CYC_I  in  1  Wishbone cycle
STB_I  in  1  Wishbone strobe
WE_I  in  1  Wishbone write enable
ADR_I  in  8  byte address; bits [7:2] decoded
DAT_I  in  32  write data
SEL_I  in  4  byte lane selects
ACK_O  out  1  Wishbone acknowledge
DAT_O  out  32  read data
src_i  in  NUM_SRC  raw asynchronous interrupt sources; bit i-1 is ID i
irq_o  out  1  interrupt request to core

Behaviour:
- Reset (RST_I low, asynchronous): all registers, pending, in-service and synchroniser flops clear to 0. ACK_O=0, DAT_O=0, irq_o=0. The controller is immediately usable after RST_I rises.
- Register map (ADR_I[7:2]):
  - 0x00 PENDING, RO.
  - 0x04 ENABLE, RW.
  - 0x08 MODE, RW; 1=edge, 0=level.
  - 0x0C THRESHOLD, RW, PRIO_W bits.
  - 0x10 CLAIM/COMPLETE.
  - 0x40+4*(i-1) PRIORITY[i], RW, PRIO_W bits.
  - Bit i-1 of each bitmap register is source i. Unimplemented bits read 0. Unmapped addresses read 0 and ignore writes.
- Wishbone:
  - ACK_O <= CYC_I & STB_I & ~ACK_O, giving a single-cycle ACK one cycle after the strobe.
  - Read data is valid in DAT_O while ACK_O=1.
  - All side effects occur on the ACK cycle.
  - RW registers honour SEL_I byte lanes.
  - CLAIM/COMPLETE ignores SEL_I.
- Source path: src_i passes through SYNC_STAGES flops. Edge detect compares the synchronised value with its previous cycle (rising edge only).
- Pending:
  - Edge mode: pending bit is set on a rising edge and cleared by a claim of that ID. If a set and a clear occur in the same cycle, the set wins.
  - Level mode: pending equals the synchronised level; it is not stored.
  - Changing MODE clears any stored edge-pending bit for that source.
- Eligibility: pending & ENABLE & ~in_service & (PRIORITY > THRESHOLD).
- Arbitration:
  - The highest PRIORITY wins; on a tie, the lowest ID wins.
  - The result is registered as best_id (1-cycle latency from an eligibility change to best_id/irq_o).
  - irq_o = (best_id != 0), registered.
- Claim (read of 0x10):
  - Returns the current best_id.
  - If best_id != 0, sets in_service[best_id] and, in edge mode, clears its pending bit in the same cycle.
  - If best_id = 0, returns 0 with no side effect.
- Complete (write of 0x10): DAT_I[4:0]=ID clears in_service[ID]. A write of ID 0, an ID > NUM_SRC, or an ID not in service is ignored.
- A level source still asserted after complete becomes eligible again on the next cycle.
- Multiple sources may be in service at once (nesting). While any source is in service, a new source interrupts only if it is otherwise eligible.
- irq_o is not forced low on claim. It follows the next best_id one cycle after the claim ACK.
- Reset asserted mid-transfer: the transfer is abandoned, ACK_O drops immediately, and no side effects occur.

Test Plan:
- Reset, then read every register → all read 0; irq_o=0; ACK_O pulses exactly one cycle per access.
- Source 3: edge mode, ENABLE=0x04, PRIORITY[3]=2, THRESHOLD=0; pulse src_i[2] for 1 cycle → irq_o rises SYNC_STAGES+2 cycles later; claim reads 3; irq_o falls next cycle; PENDING=0; write complete 3 → in_service cleared.
- Sources 2 and 5 both level-high, enabled, priorities 4 and 4 → claim returns 2; second claim returns 5; third claim returns 0 with no side effect.
- Priorities 1 vs 6, THRESHOLD=5 → only the source with priority 6 is claimable; set THRESHOLD=6 → irq_o=0 within 1 cycle.
- Level source held high through claim and complete → irq_o re-asserts the cycle after the complete ACK; complete of ID 9 (NUM_SRC=8) or an unclaimed ID changes nothing.
- Edge arrives on the same cycle as the claim ACK for that source → pending remains 1, and the source is claimable again after complete; RST_I pulsed low mid-cycle → ACK_O, irq_o and all state clear asynchronously.
